// File: rtl/dec_scan_reg.sv
// Registered binary-to-one-hot decoder with a direct mode and a scan mode.
// In scan mode an internal address sweeps up or down, dwelling HOLD enabled cycles per step.
module dec_scan_reg #(
  parameter int IN_W = 3,
  parameter int HOLD = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   mode,
  input  logic                   dir,
  input  logic                   load,
  input  logic [IN_W-1:0]        in,
  output logic [(1<<IN_W)-1:0]   out,
  output logic [IN_W-1:0]        idx,
  output logic                   wrap
);

  localparam int OUT_W = 1 << IN_W;
  localparam int HC_W  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD - 1);

  logic [HC_W-1:0]  hcnt, hcnt_nxt;
  logic [IN_W-1:0]  idx_nxt;
  logic [IN_W-1:0]  sel;
  logic [OUT_W-1:0] out_nxt;
  logic             wrap_nxt;

  // Scan address and dwell counter; load beats a step, en=0 freezes everything.
  always_comb begin
    idx_nxt  = idx;
    hcnt_nxt = hcnt;
    wrap_nxt = 1'b0;
    if (mode) begin
      if (load) begin
        idx_nxt  = in;
        hcnt_nxt = '0;
      end else if (en) begin
        if (hcnt == HC_LAST) begin
          hcnt_nxt = '0;
          if (dir) begin
            idx_nxt  = idx - IN_W'(1);
            wrap_nxt = (idx == '0);
          end else begin
            idx_nxt  = idx + IN_W'(1);
            wrap_nxt = (idx == '1);
          end
        end else begin
          hcnt_nxt = hcnt + HC_W'(1);
        end
      end
    end
  end

  // Decode the value idx takes at this edge so out tracks idx with no extra lag.
  always_comb begin
    sel     = mode ? idx_nxt : in;
    out_nxt = en ? (OUT_W'(1) << sel) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out  <= '0;
      idx  <= '0;
      hcnt <= '0;
      wrap <= 1'b0;
    end else begin
      out  <= out_nxt;
      idx  <= idx_nxt;
      hcnt <= hcnt_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_dec_scan_reg.sv
// Bench for dec_scan_reg: three instances (HOLD=1,2,3) share the stimulus and are
// compared against a dwell-count reference model plus directed expected values.
module tb_dec_scan_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b1, en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
  logic [2:0] din = '0;
  logic [2:0][7:0] o;
  logic [2:0][2:0] ix;
  logic [2:0]      w;

  int total = 0;
  int bad = 0;

  // Reference state: address, enabled cycles spent at the current address, outputs.
  int       m_idx[3];
  int       m_ph[3];
  logic [7:0] m_out[3];
  logic     m_wrap[3];

  always #5 clk = ~clk;

  dec_scan_reg #(.IN_W(3), .HOLD(1)) dut_h1 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .dir(dir), .load(load), .in(din), .out(o[0]), .idx(ix[0]), .wrap(w[0]));
  dec_scan_reg #(.IN_W(3), .HOLD(2)) dut_h2 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .dir(dir), .load(load), .in(din), .out(o[1]), .idx(ix[1]), .wrap(w[1]));
  dec_scan_reg #(.IN_W(3), .HOLD(3)) dut_h3 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .dir(dir), .load(load), .in(din), .out(o[2]), .idx(ix[2]), .wrap(w[2]));

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_idx[k] = 0; m_ph[k] = 0; m_out[k] = 8'h00; m_wrap[k] = 1'b0;
      end else if (!mode) begin
        m_out[k]  = en ? 8'(1 << din) : 8'h00;
        m_wrap[k] = 1'b0;
      end else begin
        m_wrap[k] = 1'b0;
        if (load) begin
          m_idx[k] = int'(din);
          m_ph[k]  = 0;
        end else if (en) begin
          m_ph[k]++;
          if (m_ph[k] == k + 1) begin
            m_ph[k] = 0;
            if (!dir) begin
              m_wrap[k] = (m_idx[k] == 7);
              m_idx[k]  = (m_idx[k] + 1) % 8;
            end else begin
              m_wrap[k] = (m_idx[k] == 0);
              m_idx[k]  = (m_idx[k] + 7) % 8;
            end
          end
        end
        m_out[k] = en ? 8'(1 << m_idx[k]) : 8'h00;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'($urandom); dir = 1'($urandom);
    load = 1'($urandom); din = 3'($urandom);
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({o[k], ix[k], w[k]} !== 12'h000) begin
        bad++;
        $display("[TB] FAIL reset inst%0d got out=%h idx=%0d wrap=%b want 00/0/0", k, o[k], ix[k], w[k]);
      end
    end
  endtask

  task automatic test_direct();
    mode = 1'b0;
    for (int c = 0; c < 16; c++) begin
      en = c[3]; din = c[2:0]; dir = 1'($urandom); load = 1'($urandom);
      cycle();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (o[k] !== (c[3] ? 8'(1 << c[2:0]) : 8'h00) || ix[k] !== 3'(m_idx[k]) || w[k] !== 1'b0) begin
          bad++;
          $display("[TB] FAIL direct inst%0d en=%b in=%0d got out=%h idx=%0d wrap=%b want out=%h idx=%0d",
                   k, c[3], c[2:0], o[k], ix[k], w[k], c[3] ? 8'(1 << c[2:0]) : 8'h00, m_idx[k]);
        end
      end
    end
    en = 1'b1; din = 3'b101;
    cycle();
    total++;
    if (o[0] !== 8'h20) begin
      bad++;
      $display("[TB] FAIL direct_in5 got %h want 20", o[0]);
    end
  endtask

  task automatic test_scan_up();
    int nwrap;
    int e;
    nwrap = 0;
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    mode = 1'b1; en = 1'b1; dir = 1'b0; load = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      cycle();
      e = (c / 2) % 8;
      if (w[1] === 1'b1) nwrap++;
      total++;
      if (ix[1] !== 3'(e) || o[1] !== 8'(1 << e) || w[1] !== (c % 16 == 0)) begin
        bad++;
        $display("[TB] FAIL scan_up c=%0d got idx=%0d out=%h wrap=%b want idx=%0d out=%h wrap=%b",
                 c, ix[1], o[1], w[1], e, 8'(1 << e), (c % 16 == 0));
      end
      for (int k = 0; k < 3; k += 2) begin
        total++;
        if (ix[k] !== 3'(m_idx[k]) || o[k] !== m_out[k] || w[k] !== m_wrap[k]) begin
          bad++;
          $display("[TB] FAIL scan_up_model inst%0d got idx=%0d out=%h wrap=%b want idx=%0d out=%h wrap=%b",
                   k, ix[k], o[k], w[k], m_idx[k], m_out[k], m_wrap[k]);
        end
      end
    end
    total++;
    if (nwrap != 2) begin
      bad++;
      $display("[TB] FAIL scan_up_wrapcount got %0d want 2", nwrap);
    end
  endtask

  task automatic test_scan_down();
    mode = 1'b1; en = 1'b1; dir = 1'b1; load = 1'b1; din = 3'b001;
    cycle();
    load = 1'b0;
    total++;
    if (ix[0] !== 3'd1 || o[0] !== 8'h02) begin
      bad++;
      $display("[TB] FAIL scan_down_load got idx=%0d out=%h want 1/02", ix[0], o[0]);
    end
    cycle();
    total++;
    if (ix[0] !== 3'd0 || o[0] !== 8'h01 || w[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL scan_down_0 got idx=%0d out=%h wrap=%b want 0/01/0", ix[0], o[0], w[0]);
    end
    cycle();
    total++;
    if (ix[0] !== 3'd7 || o[0] !== 8'h80 || w[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL scan_down_wrap got idx=%0d out=%h wrap=%b want 7/80/1", ix[0], o[0], w[0]);
    end
  endtask

  task automatic test_collision();
    mode = 1'b1; en = 1'b1; dir = 1'b0; load = 1'b1; din = 3'd7;
    cycle();
    din = 3'b100;
    cycle();
    load = 1'b0;
    total++;
    if (ix[0] !== 3'd4 || o[0] !== 8'h10 || w[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL collision got idx=%0d out=%h wrap=%b want 4/10/0", ix[0], o[0], w[0]);
    end
  endtask

  task automatic test_en_gating();
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    mode = 1'b1; en = 1'b1; dir = 1'b0; load = 1'b0;
    cycle();
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      total++;
      if (o[2] !== 8'h00 || ix[2] !== 3'd0 || w[2] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL en_off c=%0d got out=%h idx=%0d want 00/0", c, o[2], ix[2]);
      end
    end
    en = 1'b1;
    cycle();
    total++;
    if (ix[2] !== 3'd0 || o[2] !== 8'h01) begin
      bad++;
      $display("[TB] FAIL en_resume1 got idx=%0d out=%h want 0/01", ix[2], o[2]);
    end
    cycle();
    total++;
    if (ix[2] !== 3'd1 || o[2] !== 8'h02) begin
      bad++;
      $display("[TB] FAIL en_resume2 got idx=%0d out=%h want 1/02", ix[2], o[2]);
    end
  endtask

  task automatic test_reset_mid_scan();
    mode = 1'b1; en = 1'b1; load = 1'b1; din = 3'd5;
    cycle();
    load = 1'b0; en = 1'b0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ix[k] !== 3'd5 || o[k] !== 8'h00) begin
        bad++;
        $display("[TB] FAIL rst_glitch inst%0d got idx=%0d out=%h want 5/00", k, ix[k], o[k]);
      end
    end
    en = 1'b1; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({o[k], ix[k], w[k]} !== 12'h000) begin
        bad++;
        $display("[TB] FAIL rst_mid inst%0d got out=%h idx=%0d wrap=%b want 00/0/0", k, o[k], ix[k], w[k]);
      end
    end
    cycle();
    total++;
    if (o[2] !== 8'h01 || o[0] !== 8'h02) begin
      bad++;
      $display("[TB] FAIL rst_release got h3=%h h1=%h want 01/02", o[2], o[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      rst_n = ($urandom % 50) != 0;
      en    = ($urandom % 8) != 0;
      mode  = ($urandom % 6) != 0;
      load  = ($urandom % 10) == 0;
      dir   = 1'($urandom);
      din   = 3'($urandom);
      cycle();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (ix[k] !== 3'(m_idx[k]) || o[k] !== m_out[k] || w[k] !== m_wrap[k] || $countones(o[k]) > 1) begin
          bad++;
          $display("[TB] FAIL random c=%0d inst%0d got idx=%0d out=%h wrap=%b want idx=%0d out=%h wrap=%b",
                   c, k, ix[k], o[k], w[k], m_idx[k], m_out[k], m_wrap[k]);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0; m_ph[k] = 0; m_out[k] = 8'h00; m_wrap[k] = 1'b0;
    end
    #1;
    test_reset();
    test_direct();
    test_scan_up();
    test_scan_down();
    test_collision();
    test_en_gating();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dec_scan_reg.md
# dec_scan_reg

Parametrised, registered binary-to-one-hot decoder: the next-generation successor to the 3-to-8 enable decoders. It decodes an IN_W-bit address into a 2^IN_W one-hot output with enable. It adds a scan mode, in which an internal address counter sweeps the outputs up or down at a programmable dwell rate with load and wrap indication. It drives row/digit-select lines (LED matrices, multiplexed 7-segment displays) in the practice designs.

## Interface

- IN_W, 3, address width; output width is OUT_W = 2**IN_W (derived, not overridable); legal 1..6
- HOLD, 1, enabled clock cycles per scan step; legal >= 1
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low; one clock, sampled on rising edge of clk
- en  input  1  enable; 0 forces out to zero and freezes scan state
- mode  input  1  0 = direct decode of in, 1 = scan
- dir  input  1  scan direction: 0 = up (idx+1), 1 = down (idx-1)
- load  input  1  scan mode only: load idx from in
- in  input  IN_W  address (direct mode) / load value (scan mode)
- out  output  OUT_W  registered one-hot (or all-zero) select
- idx  output  IN_W  current scan address register
- wrap  output  1  registered one-cycle pulse on scan wrap-around

## Operation

- State: idx (IN_W bits), hcnt dwell counter (width max(1, clog2(HOLD))), out, wrap.
- Reset (rst_n=0 at edge): out=0, idx=0, hcnt=0, wrap=0; overrides all other inputs.
- Direct mode (mode=0):
  - out <= en ? (1 << in) : 0.
  - idx and hcnt hold; wrap <= 0; load and dir ignored.
- Scan mode (mode=1), priority load > advance:
  - load=1: idx <= in, hcnt <= 0, wrap <= 0. Load is honoured regardless of en.
  - else en=1 and hcnt==HOLD-1: hcnt <= 0; idx <= idx+1 (dir=0) or idx-1 (dir=1), modulo 2^IN_W. wrap <= 1 if the step crosses 2^IN_W-1 -> 0 (up) or 0 -> 2^IN_W-1 (down), else 0.
  - else en=1: hcnt <= hcnt+1, idx holds, wrap <= 0.
  - en=0: idx and hcnt frozen, wrap <= 0.
  - out <= en ? (1 << idx_next) : 0, where idx_next is the value idx takes at the same edge. In scan mode with en=1, out is therefore always the one-hot decode of the idx output.
- Output invariant: out is one-hot or all-zero at all times; never multi-hot.
- Arithmetic: idx wraps silently modulo 2^IN_W. hcnt never exceeds HOLD-1. HOLD=1 means idx steps every enabled cycle.

## Timing

- Latency: one clock from in/en/mode/idx change to out. No combinational path from inputs to any output.
- Mode switch 0->1: the first scan edge uses the held idx. out shows 1<<idx, or the stepped value if hcnt==HOLD-1 at that edge. hcnt is not cleared by a mode switch.
- Mode switch 1->0: the next edge gives out = 1<<in. idx and hcnt are retained for a later return to scan.
- dir change mid-dwell: takes effect at the next step edge; hcnt is not reset.
- Simultaneous load and step condition: load wins, no step, no wrap.
- en deassert mid-dwell: hcnt is kept; the dwell resumes where it stopped when en returns.
- Reset mid-scan: all state clears at that edge. The first enabled scan edge after release gives out=8'h01 (IN_W=3) if HOLD>1.

## Test plan

- Direct sweep, IN_W=3: all 16 {en,in} combinations. en=0 -> out=8'h00. en=1,in=k -> out=1<<k one edge later, e.g. in=3'b101 -> 8'h20.
- Scan up, HOLD=2, en=1, mode=1, dir=0 from reset: idx goes 0,0,1,1,...,7,7,0. out=1<<idx every cycle. wrap=1 for exactly the cycle idx becomes 0. Period is 16 clocks.
- Scan down, HOLD=1, load in=3'b001: next idx=1, then 0, then 7 with wrap=1, out=8'h80.
- Load/step collision: HOLD=1, idx=7, dir=0, load=1 with in=3'b100 -> idx=4, out=8'h10, wrap stays 0.
- en gating: scan HOLD=3, drop en for 5 cycles mid-dwell -> out=8'h00 and idx/hcnt frozen. On re-enable the step occurs after the remaining dwell count only.
- Synchronous reset mid-scan: assert rst_n=0 while idx=5 -> at that edge out=0, idx=0, wrap=0. rst_n low between edges has no effect until the next edge.
